serial_addsub: RTL and testbench



---
 rtl/serial_addsub_if.sv | 35 +++
 rtl/serial_addsub.sv | 178 +++++++++++++++++
 tb/tb_serial_addsub.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/serial_addsub_if.sv
// Operand/result handshake bundle for serial_addsub.
// The optional zero flag exists only when SERIAL_ADDSUB_ZERO_EN is defined.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cb_out;
  logic             ovf;
`ifdef SERIAL_ADDSUB_ZERO_EN
  logic             zero;
`endif

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, cb_out, ovf
`ifdef SERIAL_ADDSUB_ZERO_EN
    , input zero
`endif
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, cb_out, ovf
`ifdef SERIAL_ADDSUB_ZERO_EN
    , output zero
`endif
  );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial two's-complement adder/subtractor, one bit per clock, LSB first.
// Optional zero-result flag is enabled by defining SERIAL_ADDSUB_ZERO_EN.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst_n,
  serial_addsub_if.slave bus
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [WIDTH-1:0]   a_sh_r;
  logic [WIDTH-1:0]   b_sh_r;
  logic [WIDTH-1:0]   res_sh_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               op_r;
  logic               c_r;
  logic               a_msb_r;
  logic               b_msb_r;
  logic [WIDTH-1:0]   result_r;
  logic               cb_r;
  logic               ovf_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic [1:0]         cell_s;
  logic               last_s;
  logic               ovf_s;
  logic [WIDTH-1:0]   res_next_s;

  // One full-adder / full-subtractor cell: returns {carry_or_borrow, sum_or_diff}.
  function automatic logic [1:0] addsub_cell(input logic x, input logic y,
                                             input logic c, input logic sub);
    logic s;
    logic co;
    s = x ^ y ^ c;
    if (sub) begin
      co = (~x & y) | (~(x ^ y) & c);
    end else begin
      co = (x & y) | ((x ^ y) & c);
    end
    return {co, s};
  endfunction

  // Bit-cell evaluation, final result assembly and signed-overflow decision.
  always_comb begin
    cell_s     = addsub_cell(a_sh_r[0], b_sh_r[0], c_r, op_r);
    last_s     = (state_r == RUN) && (cnt_r == CNT_W'(WIDTH - 1));
    res_next_s = {cell_s[0], res_sh_r[WIDTH-1:1]};
    // Overflow judged from the original operand MSBs, latched at accept.
    if (op_r) begin
      ovf_s = (a_msb_r != b_msb_r) && (cell_s[0] != a_msb_r);
    end else begin
      ovf_s = (a_msb_r == b_msb_r) && (cell_s[0] != a_msb_r);
    end
  end

  // Next-state logic for the IDLE/RUN/DONE controller.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register plus registered handshake flags decoded from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
    end
  end

  // Operand shift registers, carry/borrow flop, counter and held result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh_r   <= '0;
      b_sh_r   <= '0;
      res_sh_r <= '0;
      cnt_r    <= '0;
      op_r     <= 1'b0;
      c_r      <= 1'b0;
      a_msb_r  <= 1'b0;
      b_msb_r  <= 1'b0;
      result_r <= '0;
      cb_r     <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh_r  <= bus.a;
            b_sh_r  <= bus.b;
            op_r    <= bus.op;
            a_msb_r <= bus.a[WIDTH-1];
            b_msb_r <= bus.b[WIDTH-1];
            c_r     <= 1'b0;
            cnt_r   <= '0;
          end
        end
        RUN: begin
          a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
          res_sh_r <= res_next_s;
          c_r      <= cell_s[1];
          cnt_r    <= cnt_r + CNT_W'(1);
          if (last_s) begin
            result_r <= res_next_s;
            cb_r     <= cell_s[1];
            ovf_r    <= ovf_s;
          end
        end
        DONE: begin
          c_r <= c_r;
        end
        default: begin
          c_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef SERIAL_ADDSUB_ZERO_EN
  logic zero_r;

  // Zero flag captured with the result at the final RUN edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zero_r <= 1'b0;
    end else if (last_s) begin
      zero_r <= (res_next_s == '0);
    end else begin
      zero_r <= zero_r;
    end
  end

  assign bus.zero = zero_r;
`endif

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;
  assign bus.cb_out    = cb_r;
  assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: directed table, backpressure, mid-run reset
// and randomized operations against an arithmetic reference model.
module tb_serial_addsub;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  serial_addsub_if #(.WIDTH(WIDTH)) bus ();
  serial_addsub #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] res;
    logic             cb;
    logic             ovf;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic void model(input logic op, input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b, output logic [WIDTH-1:0] res,
                                output logic cb, output logic ovf);
    int ua, ub, sa, sb, s;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (!op) begin
      res = WIDTH'(ua + ub);
      cb  = (ua + ub) > ((1 << WIDTH) - 1);
      s   = sa + sb;
    end else begin
      res = WIDTH'(ua - ub);
      cb  = ua < ub;
      s   = sa - sb;
    end
    ovf = (s > ((1 << (WIDTH - 1)) - 1)) || (s < -(1 << (WIDTH - 1)));
  endfunction

  task automatic run_op(input logic op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input int hold, output logic [WIDTH-1:0] res, output logic cb,
                        output logic ovf, output logic zr);
    int w;
    int n;
    logic [WIDTH-1:0] prev;
    w = 0;
    while (!bus.in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    check("in_ready_before_issue", 32'(bus.in_ready), 32'd1);
    bus.op = op; bus.a = a; bus.b = b; bus.in_valid = 1'b1;
    prev = bus.result;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = WIDTH'($urandom); bus.b = WIDTH'($urandom); bus.op = 1'($urandom);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (n == 4) check("result_held_during_run", 32'(bus.result), 32'(prev));
    end
    check("latency", 32'(n), 32'(WIDTH));
    res = bus.result; cb = bus.cb_out; ovf = bus.ovf;
`ifdef SERIAL_ADDSUB_ZERO_EN
    zr = bus.zero;
`else
    zr = (bus.result == '0);
`endif
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'($urandom);
      bus.a = WIDTH'($urandom); bus.b = WIDTH'($urandom);
      @(posedge clk); #1;
      check("bp_result_stable", 32'(bus.result), 32'(res));
      check("bp_flags_stable", {30'd0, bus.cb_out, bus.ovf}, {30'd0, cb, ovf});
      check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
      check("bp_out_valid_high", 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("drain_in_ready", 32'(bus.in_ready), 32'd1);
    check("drain_out_valid", 32'(bus.out_valid), 32'd0);
    check("result_kept_after_drain", 32'(bus.result), 32'(res));
  endtask

  initial begin
    logic [WIDTH-1:0] r, er;
    logic c, o, z, ec, eo;

    tbl[0] = '{1'b0, 8'h3C, 8'h15, 8'h51, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};

    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op = 1'b0;
    bus.a = '0; bus.b = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_result", 32'(bus.result), 32'd0);
    check("reset_flags", {30'd0, bus.cb_out, bus.ovf}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, 0, r, c, o, z);
      check($sformatf("tbl%0d_result", i), 32'(r), 32'(tbl[i].res));
      check($sformatf("tbl%0d_cb_out", i), 32'(c), 32'(tbl[i].cb));
      check($sformatf("tbl%0d_ovf", i), 32'(o), 32'(tbl[i].ovf));
      check($sformatf("tbl%0d_zero", i), 32'(z), 32'(tbl[i].res == '0));
    end

    for (int i = 0; i < 40; i++) begin
      logic rop;
      logic [WIDTH-1:0] ra, rb;
      rop = 1'($urandom); ra = WIDTH'($urandom); rb = WIDTH'($urandom);
      model(rop, ra, rb, er, ec, eo);
      run_op(rop, ra, rb, $urandom_range(0, 2), r, c, o, z);
      check("rand_result", 32'(r), 32'(er));
      check("rand_cb_out", 32'(c), 32'(ec));
      check("rand_ovf", 32'(o), 32'(eo));
      check("rand_zero", 32'(z), 32'(er == '0));
    end

    // Backpressure: five stalled cycles with stray in_valid pulses.
    run_op(1'b0, 8'h3C, 8'h15, 5, r, c, o, z);
    check("bp_result", 32'(r), 32'h51);
    check("bp_no_spurious_accept", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    check("bp_still_idle", 32'(bus.in_ready), 32'd1);

    // Reset while the add is processing bit 3.
    bus.op = 1'b0; bus.a = 8'h3C; bus.b = 8'h15; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_result", 32'(bus.result), 32'd0);
    check("midrst_flags", {30'd0, bus.cb_out, bus.ovf}, 32'd0);
    run_op(1'b1, 8'h05, 8'h03, 0, r, c, o, z);
    check("post_rst_result", 32'(r), 32'h02);
    check("post_rst_flags", {30'd0, c, o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
